l2_readout: RTL and testbench

- Downstream of the 3-neuron L2 layer/trainer pair. Consumes the L2 output spikes and the active supervisory label over one sample window.
- Per window, decides a predicted class (one-hot) and flags whether it matches the label.
- Keeps running sample and hit counters for accuracy readout during training and inference.

---
 rtl/l2_readout.sv | 232 +++++++++++++++++++++++
 tb/tb_l2_readout.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_readout.sv
// l2_readout: per-window class decision and accuracy statistics for the
// 3-neuron L2 layer. Counts spikes per class over a sample window, picks the
// winning class, compares it with the latched supervisory label and keeps
// running sample/hit counters.
// Optional build macro: L2_READOUT_FIRST_SPIKE_EN (prediction = first class
// to spike instead of the class with the highest count).
module l2_readout #(
  parameter int p_cnt_w  = 6,
  parameter int p_stat_w = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [2:0]          i_spike,
  input  logic [2:0]          i_label,
  input  logic                i_sample_start,
  input  logic                i_sample_end,
  input  logic                i_gas,
  input  logic                i_stat_clr,
  output logic [2:0]          o_pred,
  output logic                o_pred_valid,
  output logic                o_correct,
  output logic                o_no_spike,
  output logic [p_stat_w-1:0] o_sample_cnt,
  output logic [p_stat_w-1:0] o_hit_cnt,
  output logic [p_cnt_w-1:0]  o_gas_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DECIDE = 2'd2
  } state_t;

  localparam logic [p_cnt_w-1:0]  LP_CNT_MAX  = {p_cnt_w{1'b1}};
  localparam logic [p_cnt_w-1:0]  LP_CNT_ZERO = {p_cnt_w{1'b0}};
  localparam logic [p_cnt_w-1:0]  LP_CNT_ONE  = {{(p_cnt_w-1){1'b0}}, 1'b1};
  localparam logic [p_stat_w-1:0] LP_ST_MAX   = {p_stat_w{1'b1}};
  localparam logic [p_stat_w-1:0] LP_ST_ZERO  = {p_stat_w{1'b0}};
  localparam logic [p_stat_w-1:0] LP_ST_ONE   = {{(p_stat_w-1){1'b0}}, 1'b1};

  // Saturating increment for the per-class and gas counters.
  function automatic logic [p_cnt_w-1:0] f_cnt_inc(input logic [p_cnt_w-1:0] v, input logic en);
    return (en && (v != LP_CNT_MAX)) ? (v + LP_CNT_ONE) : v;
  endfunction

  // Saturating increment for the statistics counters.
  function automatic logic [p_stat_w-1:0] f_stat_inc(input logic [p_stat_w-1:0] v);
    return (v != LP_ST_MAX) ? (v + LP_ST_ONE) : v;
  endfunction

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_start_pend;
  logic                     w_open;
  logic                     w_count_en;
  logic [2:0][p_cnt_w-1:0]  r_cnt;
  logic [p_cnt_w-1:0]       r_gas;
  logic [2:0]               r_label;
  logic                     w_label_oh;
  logic                     w_all_zero;
  logic [2:0]               w_dec_pred;
  logic                     w_dec_correct;
  logic                     w_decide;
  logic [2:0]               r_pred;
  logic                     r_pred_valid;
  logic                     r_correct;
  logic                     r_no_spike;
  logic [p_stat_w-1:0]      r_sample_cnt;
  logic [p_stat_w-1:0]      r_hit_cnt;
  logic [p_cnt_w-1:0]       r_gas_last;
`ifdef L2_READOUT_FIRST_SPIKE_EN
  logic [2:0]               r_first;
`endif

  assign w_label_oh    = (i_label == 3'b001) || (i_label == 3'b010) || (i_label == 3'b100);
  assign w_decide      = (r_state == ST_DECIDE);
  assign w_dec_correct = (r_label != 3'b000) && (r_label == w_dec_pred);

  // Window sequencing: open (or restart) a window, accumulate, decide.
  always_comb begin
    w_state_nxt = r_state;
    w_open      = 1'b0;
    w_count_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_sample_start || r_start_pend) begin
          w_state_nxt = ST_ACCUM;
          w_open      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (i_sample_start) begin
          w_state_nxt = ST_ACCUM;
          w_open      = 1'b1;
        end else if (i_sample_end) begin
          w_state_nxt = ST_DECIDE;
          w_count_en  = 1'b1;
        end else begin
          w_state_nxt = ST_ACCUM;
          w_count_en  = 1'b1;
        end
      end
      ST_DECIDE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus the one-cycle hold of a start that lands in DECIDE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_start_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_pend <= w_decide && i_sample_start;
    end
  end

  // Per-class and gas counters: cleared on window open, counted in ACCUM.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_gas <= LP_CNT_ZERO;
    end else if (w_open) begin
      r_cnt <= '0;
      r_gas <= LP_CNT_ZERO;
    end else if (w_count_en) begin
      for (int k = 0; k < 3; k++) begin
        r_cnt[k] <= f_cnt_inc(r_cnt[k], i_spike[k]);
      end
      r_gas <= f_cnt_inc(r_gas, i_gas);
    end else begin
      r_cnt <= r_cnt;
      r_gas <= r_gas;
    end
  end

  // Label latch: first one-hot label seen in the window, start cycle included.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_label <= 3'b000;
    end else if (w_open) begin
      r_label <= w_label_oh ? i_label : 3'b000;
    end else if (w_count_en && (r_label == 3'b000) && w_label_oh) begin
      r_label <= i_label;
    end else begin
      r_label <= r_label;
    end
  end

`ifdef L2_READOUT_FIRST_SPIKE_EN
  // First-spike capture: lowest set bit of the first non-zero spike vector.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_first <= 3'b000;
    end else if (w_open) begin
      r_first <= 3'b000;
    end else if (w_count_en && (r_first == 3'b000) && (i_spike != 3'b000)) begin
      r_first <= i_spike & (~i_spike + 3'b001);
    end else begin
      r_first <= r_first;
    end
  end
`endif

  // Decision: winning class of the window (ties resolve to lowest index).
  always_comb begin
    w_all_zero = (r_cnt[0] == LP_CNT_ZERO) && (r_cnt[1] == LP_CNT_ZERO) &&
                 (r_cnt[2] == LP_CNT_ZERO);
`ifdef L2_READOUT_FIRST_SPIKE_EN
    w_dec_pred = r_first;
`else
    w_dec_pred = 3'b000;
    if (w_all_zero) begin
      w_dec_pred = 3'b000;
    end else if ((r_cnt[0] >= r_cnt[1]) && (r_cnt[0] >= r_cnt[2])) begin
      w_dec_pred = 3'b001;
    end else if (r_cnt[1] >= r_cnt[2]) begin
      w_dec_pred = 3'b010;
    end else begin
      w_dec_pred = 3'b100;
    end
`endif
  end

  // Registered decision outputs, refreshed once per completed window.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pred       <= 3'b000;
      r_pred_valid <= 1'b0;
      r_correct    <= 1'b0;
      r_no_spike   <= 1'b0;
      r_gas_last   <= LP_CNT_ZERO;
    end else if (w_decide) begin
      r_pred       <= w_dec_pred;
      r_pred_valid <= 1'b1;
      r_correct    <= w_dec_correct;
      r_no_spike   <= w_all_zero;
      r_gas_last   <= r_gas;
    end else begin
      r_pred_valid <= 1'b0;
    end
  end

  // Accuracy statistics: labelled windows and hits, clear has priority.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sample_cnt <= LP_ST_ZERO;
      r_hit_cnt    <= LP_ST_ZERO;
    end else if (i_stat_clr) begin
      r_sample_cnt <= LP_ST_ZERO;
      r_hit_cnt    <= LP_ST_ZERO;
    end else if (w_decide && (r_label != 3'b000)) begin
      r_sample_cnt <= f_stat_inc(r_sample_cnt);
      r_hit_cnt    <= w_dec_correct ? f_stat_inc(r_hit_cnt) : r_hit_cnt;
    end else begin
      r_sample_cnt <= r_sample_cnt;
      r_hit_cnt    <= r_hit_cnt;
    end
  end

  assign o_pred       = r_pred;
  assign o_pred_valid = r_pred_valid;
  assign o_correct    = r_correct;
  assign o_no_spike   = r_no_spike;
  assign o_sample_cnt = r_sample_cnt;
  assign o_hit_cnt    = r_hit_cnt;
  assign o_gas_cnt    = r_gas_last;

endmodule

// File: tb/tb_l2_readout.sv
// Bench for l2_readout: directed test-plan windows with literal expectations,
// then randomized traffic checked every cycle against a window-level model.
module tb_l2_readout;
  localparam int CW = 3;
  localparam int SW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    spike = 3'b000;
  logic [2:0]    label = 3'b000;
  logic          sstart = 1'b0;
  logic          send = 1'b0;
  logic          gas = 1'b0;
  logic          sclr = 1'b0;
  logic [2:0]    pred;
  logic          pred_valid;
  logic          correct;
  logic          no_spike;
  logic [SW-1:0] sample_cnt;
  logic [SW-1:0] hit_cnt;
  logic [CW-1:0] gas_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  bit chk_en  = 1'b0;

  l2_readout #(.p_cnt_w(CW), .p_stat_w(SW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_spike(spike), .i_label(label),
    .i_sample_start(sstart), .i_sample_end(send), .i_gas(gas), .i_stat_clr(sclr),
    .o_pred(pred), .o_pred_valid(pred_valid), .o_correct(correct),
    .o_no_spike(no_spike), .o_sample_cnt(sample_cnt), .o_hit_cnt(hit_cnt),
    .o_gas_cnt(gas_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (window level) ----------------
  bit         m_open, m_closing, m_pend;
  int         m_cnt[3];
  int         m_gas;
  logic [2:0] m_label, m_first;
  logic [2:0] e_pred;
  bit         e_valid, e_correct, e_nospike;
  int         e_sample, e_hit, e_gas;

  function automatic bit is_onehot(input logic [2:0] v);
    return $countones(v) == 1;
  endfunction

  task automatic m_begin_window();
    m_open = 1'b1;
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    m_gas = 0;
    m_first = 3'b000;
    m_label = is_onehot(label) ? label : 3'b000;
  endtask

  task automatic m_decide();
    int best;
    int bestv;
    best = -1;
    bestv = 0;
    for (int k = 0; k < 3; k++) begin
      if (m_cnt[k] > bestv) begin
        best = k;
        bestv = m_cnt[k];
      end
    end
`ifdef L2_READOUT_FIRST_SPIKE_EN
    e_pred = m_first;
`else
    e_pred = (best < 0) ? 3'b000 : 3'(1 << best);
`endif
    e_nospike = (best < 0);
    e_correct = (m_label != 3'b000) && (m_label == e_pred);
    e_gas = m_gas;
    e_valid = 1'b1;
    if (m_label != 3'b000) begin
      if (e_sample < SMAX) e_sample++;
      if (e_correct && e_hit < SMAX) e_hit++;
    end
  endtask

  // Model advances on each active edge from the inputs the bench drove.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_open = 0; m_closing = 0; m_pend = 0;
      e_pred = 3'b000; e_valid = 0; e_correct = 0; e_nospike = 0;
      e_sample = 0; e_hit = 0; e_gas = 0;
      chk_en = 1'b1;
    end else begin
      e_valid = 1'b0;
      if (m_closing) begin
        m_decide();
        m_closing = 1'b0;
        m_pend = sstart;
      end else if (m_open) begin
        if (sstart) begin
          m_begin_window();
        end else begin
          for (int k = 0; k < 3; k++)
            if (spike[k] && m_cnt[k] < CMAX) m_cnt[k]++;
          if (gas && m_gas < CMAX) m_gas++;
          if (m_first == 3'b000) begin
            for (int k = 2; k >= 0; k--)
              if (spike[k]) m_first = 3'(1 << k);
          end
          if (m_label == 3'b000 && is_onehot(label)) m_label = label;
          if (send) begin
            m_open = 1'b0;
            m_closing = 1'b1;
          end
        end
      end else begin
        if (sstart || m_pend) m_begin_window();
        m_pend = 1'b0;
      end
      if (sclr) begin
        e_sample = 0;
        e_hit = 0;
      end
    end
  end

  // Compare process: DUT outputs against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (pred_valid === 1'b1) n_valid++;
      chk("pred_valid", {31'd0, pred_valid}, {31'd0, e_valid});
      chk("pred", {29'd0, pred}, {29'd0, e_pred});
      chk("gas_cnt", {29'd0, gas_cnt}, e_gas);
      chk("sample_cnt", {28'd0, sample_cnt}, e_sample);
      chk("hit_cnt", {28'd0, hit_cnt}, e_hit);
      if (e_valid) begin
        chk("correct", {31'd0, correct}, {31'd0, e_correct});
        chk("no_spike", {31'd0, no_spike}, {31'd0, e_nospike});
      end
    end
  end

  // One clock of stimulus; returns just after the following falling edge.
  task automatic cyc(input logic s, input logic e, input logic [2:0] sp,
                     input logic [2:0] lb, input logic g, input logic c);
    sstart = s; send = e; spike = sp; label = lb; gas = g; sclr = c;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
  endtask

  int v0;

  initial begin
    // Reset state
    idle(2);
    chk("rst_pred", {29'd0, pred}, 32'd0);
    chk("rst_valid", {31'd0, pred_valid}, 32'd0);
    chk("rst_sample", {28'd0, sample_cnt}, 32'd0);
    chk("rst_gas", {29'd0, gas_cnt}, 32'd0);
    rst_n = 1'b1;

    // Reset mid-window aborts without a decision
    v0 = n_valid;
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(4);
    chk("midrst_novalid", n_valid - v0, 32'd0);
    chk("midrst_pred", {29'd0, pred}, 32'd0);

    // Count decision, labelled and correct
    cyc(1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("cnt_notyet", {31'd0, pred_valid}, 32'd0);
    idle(1);
    chk("cnt_valid", {31'd0, pred_valid}, 32'd1);
    chk("cnt_pred", {29'd0, pred}, 32'h2);
    chk("cnt_correct", {31'd0, correct}, 32'd1);
    chk("cnt_sample", {28'd0, sample_cnt}, 32'd1);
    chk("cnt_hit", {28'd0, hit_cnt}, 32'd1);

    // Tie goes to lowest index
    cyc(1'b1, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    idle(1);
    chk("tie_pred", {29'd0, pred}, 32'h1);
    chk("tie_correct", {31'd0, correct}, 32'd0);
    chk("tie_sample", {28'd0, sample_cnt}, 32'd2);
    chk("tie_hit", {28'd0, hit_cnt}, 32'd1);

    // Empty window
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    idle(1);
    chk("empty_pred", {29'd0, pred}, 32'd0);
    chk("empty_nospike", {31'd0, no_spike}, 32'd1);

    // Saturation of class counter and gas counter
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 3'b100, 3'b000, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    idle(1);
    chk("sat_gas", {29'd0, gas_cnt}, 32'd7);
    chk("sat_pred", {29'd0, pred}, 32'h4);

    // Back-to-back: start arrives in the decide cycle
    v0 = n_valid;
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    chk("b2b_first_pred", {29'd0, pred}, 32'h1);
    idle(1);
    cyc(1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    idle(1);
    chk("b2b_second_pred", {29'd0, pred}, 32'h4);
    chk("b2b_count", n_valid - v0, 32'd2);

    // Restart mid-window discards the first window
    v0 = n_valid;
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    idle(2);
    chk("restart_count", n_valid - v0, 32'd1);
    chk("restart_pred", {29'd0, pred}, 32'h4);

    // First spike on class 3, then class 1 dominates by count
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    idle(1);
`ifdef L2_READOUT_FIRST_SPIKE_EN
    chk("first_pred", {29'd0, pred}, 32'h4);
`else
    chk("first_pred", {29'd0, pred}, 32'h1);
`endif

    // Stat clear wins over a same-cycle increment
    cyc(1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
    chk("clr_valid", {31'd0, pred_valid}, 32'd1);
    chk("clr_sample", {28'd0, sample_cnt}, 32'd0);
    chk("clr_hit", {28'd0, hit_cnt}, 32'd0);

    // Non-one-hot label ignored, first one-hot label latched
    cyc(1'b1, 1'b0, 3'b000, 3'b011, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'b001, 3'b001, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    idle(1);
    chk("lbl_correct", {31'd0, correct}, 32'd1);
    chk("lbl_sample", {28'd0, sample_cnt}, 32'd1);

    // Statistics saturation
    for (int w = 0; w < 17; w++) begin
      cyc(1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
      idle(1);
    end
    chk("stat_sat_sample", {28'd0, sample_cnt}, SMAX);
    chk("stat_sat_hit", {28'd0, hit_cnt}, SMAX);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] lb;
      case ($urandom_range(0, 5))
        0: lb = 3'b001;
        1: lb = 3'b010;
        2: lb = 3'b100;
        3: lb = 3'b110;
        default: lb = 3'b000;
      endcase
      rst_n = ($urandom_range(0, 299) != 0);
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
          {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0},
          lb, $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
    end
    rst_n = 1'b1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
